// File: rtl/uart_rx_core_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | uart_rx_core_if : byte handshake and status bundle of the UART receiver   |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
interface uart_rx_core_if;
  logic       rx_ack;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;

  modport master (
    input  rx_ack,
    output rx_data, rx_valid, frame_err, overrun, busy, parity_err
  );
  modport slave (
    output rx_ack,
    input  rx_data, rx_valid, frame_err, overrun, busy, parity_err
  );
`else
  modport master (
    input  rx_ack,
    output rx_data, rx_valid, frame_err, overrun, busy
  );
  modport slave (
    output rx_ack,
    input  rx_data, rx_valid, frame_err, overrun, busy
  );
`endif
endinterface
`default_nettype wire

// File: rtl/uart_rx_core.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | uart_rx_core : oversampling 8N1 UART receiver, valid/ack byte delivery    |
// | Optional even parity: define UART_RX_PARITY_EN.        Rev 1.0           |
// +--------------------------------------------------------------------------+
module uart_rx_core #(
  parameter int CLK_FREQ   = 125000000,
  parameter int BAUD_RATE  = 115200,
  parameter int OVERSAMPLE = 16
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           rx,
  uart_rx_core_if.master bus
);

  localparam int DIV_RAW = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int SW      = $clog2(OVERSAMPLE);
  localparam int M       = OVERSAMPLE / 2;

  localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] S_V0   = SW'(M - 1);
  localparam logic [SW-1:0] S_V1   = SW'(M);
  localparam logic [SW-1:0] S_V2   = SW'(M + 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    STOP   = 3'd3,
    BRK    = 3'd4
`ifdef UART_RX_PARITY_EN
    ,
    PARITY = 3'd5
`endif
  } state_t;

  state_t          state;
  state_t          state_n;

  logic            rx_meta;
  logic            rx_s;
  logic            rx_prev;

  logic            tick;
  logic            restart;
  logic [SW-1:0]   s_cnt;
  logic            v0;
  logic            v1;
  logic            vote;
  logic            vote_pt;

  logic [7:0]      shift_reg;
  logic [2:0]      bit_idx;
  logic            shift_en;
  logic            capture;
  logic            ovr_n;
  logic            ferr_n;
`ifdef UART_RX_PARITY_EN
  logic            par_bit;
  logic            par_en;
  logic            perr_n;
`endif

  // Two-flop synchronizer plus one history flop for falling-edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
    end
  end

  generate
    if (DIV == 1) begin : g_div_bypass
      assign tick = 1'b1;
    end else begin : g_div
      localparam int            DW     = $clog2(DIV);
      localparam logic [DW-1:0] D_LAST = DW'(DIV - 1);
      logic [DW-1:0] div_cnt;

      always_ff @(posedge clk) begin
        if (reset || restart || (div_cnt == D_LAST)) div_cnt <= '0;
        else                                         div_cnt <= div_cnt + 1'b1;
      end

      assign tick = (div_cnt == D_LAST);
    end
  endgenerate

  // Sample phase restarts at the start edge so the vote lands mid-bit.
  always_ff @(posedge clk) begin
    if (reset || restart)   s_cnt <= '0;
    else if (tick)          s_cnt <= (s_cnt == S_LAST) ? '0 : s_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      v0 <= 1'b0;
      v1 <= 1'b0;
    end else if (tick) begin
      if (s_cnt == S_V0) v0 <= rx_s;
      if (s_cnt == S_V1) v1 <= rx_s;
    end
  end

  assign vote_pt = tick && (s_cnt == S_V2);
  assign vote    = (v0 & v1) | (v0 & rx_s) | (v1 & rx_s);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n  = state;
    restart  = 1'b0;
    shift_en = 1'b0;
    capture  = 1'b0;
    ovr_n    = 1'b0;
    ferr_n   = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_en   = 1'b0;
    perr_n   = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (rx_prev && !rx_s) begin
          state_n = START;
          restart = 1'b1;
        end
      end
      START: begin
        if (vote_pt) state_n = vote ? IDLE : DATA;
      end
      DATA: begin
        if (vote_pt) begin
          shift_en = 1'b1;
`ifdef UART_RX_PARITY_EN
          if (bit_idx == 3'd7) state_n = PARITY;
`else
          if (bit_idx == 3'd7) state_n = STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (vote_pt) begin
          par_en  = 1'b1;
          state_n = STOP;
        end
      end
`endif
      STOP: begin
        if (vote_pt) begin
          if (!vote) begin
            ferr_n  = 1'b1;
            state_n = BRK;
          end else begin
            state_n = IDLE;
`ifdef UART_RX_PARITY_EN
            if (^{shift_reg, par_bit}) perr_n = 1'b1;
            else
`endif
            // A same-clk ack frees the holding register, so capture wins.
            if (bus.rx_valid && !bus.rx_ack) ovr_n   = 1'b1;
            else                             capture = 1'b1;
          end
        end
      end
      BRK: begin
        if (rx_s) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shift_reg     <= '0;
      bit_idx       <= '0;
      bus.rx_data   <= '0;
      bus.rx_valid  <= 1'b0;
      bus.frame_err <= 1'b0;
      bus.overrun   <= 1'b0;
    end else begin
      if (restart)       bit_idx <= '0;
      else if (shift_en) bit_idx <= bit_idx + 3'd1;

      if (shift_en) shift_reg <= {vote, shift_reg[7:1]};

      if (capture) begin
        bus.rx_data  <= shift_reg;
        bus.rx_valid <= 1'b1;
      end else if (bus.rx_ack) begin
        bus.rx_valid <= 1'b0;
      end

      bus.frame_err <= ferr_n;
      bus.overrun   <= ovr_n;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      par_bit        <= 1'b0;
      bus.parity_err <= 1'b0;
    end else begin
      if (par_en) par_bit <= vote;
      bus.parity_err <= perr_n;
    end
  end
`endif

  assign bus.busy = (state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_core.sv
`default_nettype none
// Directed bench for uart_rx_core at 16 clks per bit (DIV=1).
module tb_uart_rx_core;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic rx    = 1'b1;

  uart_rx_core_if bus();

  uart_rx_core #(
    .CLK_FREQ   (16000000),
    .BAUD_RATE  (1000000),
    .OVERSAMPLE (16)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .rx    (rx),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int   n_cmp  = 0;
  int   n_fail = 0;
  int   n_ferr = 0;
  int   n_ovr  = 0;
  int   n_rise = 0;
  int   n_busy = 0;
  logic prev_valid = 1'b0;
  logic v_at156;
  logic v_at157;
  int   f0, o0, r0, b0;

  // Pulse/edge counters sampled on the falling edge.
  always @(negedge clk) begin
    if (bus.frame_err === 1'b1) n_ferr++;
    if (bus.overrun === 1'b1)   n_ovr++;
    if (bus.busy === 1'b1)      n_busy++;
    if (bus.rx_valid === 1'b1 && prev_valid !== 1'b1) n_rise++;
    prev_valid = bus.rx_valid;
  end

  task automatic tick_n(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int edge_t(input int k, input int jit);
    if (jit != 0 && k > 0) return 16 * k + (((k % 2) == 1) ? 1 : -1);
    return 16 * k;
  endfunction

  // Drives one frame, one clk per iteration; ack_cyc<0 means no ack.
  task automatic send_frame(input logic [7:0] d, input logic stop, input int ack_cyc,
                            input int jit, input int ncyc);
    logic [9:0] frame;
    int b;
    frame = {stop, d, 1'b0};
    for (int c = 0; c < ncyc; c++) begin
      if (c == 156) v_at156 = bus.rx_valid;
      if (c == 157) v_at157 = bus.rx_valid;
      b = 0;
      for (int k = 1; k <= 10; k++) if (edge_t(k, jit) <= c) b = k;
      rx = (b < 10) ? frame[b] : 1'b1;
      bus.rx_ack = (c == ack_cyc);
      tick_n(1);
    end
    bus.rx_ack = 1'b0;
  endtask

  task automatic ack_pulse();
    bus.rx_ack = 1'b1;
    tick_n(1);
    bus.rx_ack = 1'b0;
  endtask

  initial begin
    bus.rx_ack = 1'b0;
    reset = 1'b1;
    rx    = 1'b1;
    tick_n(5);
    reset = 1'b0;
    tick_n(100);
    check("rst_valid", 32'(bus.rx_valid),  32'd0);
    check("rst_data",  32'(bus.rx_data),   32'd0);
    check("rst_ferr",  32'(bus.frame_err), 32'd0);
    check("rst_ovr",   32'(bus.overrun),   32'd0);
    check("rst_busy",  32'(bus.busy),      32'd0);

    // Clean 0xA5 and acknowledge.
    f0 = n_ferr;
    send_frame(8'hA5, 1'b1, -1, 0, 160);
    check("a5_valid",   32'(bus.rx_valid), 32'd1);
    check("a5_data",    32'(bus.rx_data),  32'hA5);
    check("a5_lat_pre", 32'(v_at156),      32'd0);
    check("a5_lat_at",  32'(v_at157),      32'd1);
    check("a5_ferr",    32'(n_ferr - f0),  32'd0);
    ack_pulse();
    check("a5_ack",     32'(bus.rx_valid), 32'd0);

    // Back-to-back without ack: second byte dropped with overrun.
    o0 = n_ovr;
    r0 = n_rise;
    send_frame(8'h00, 1'b1, -1, 0, 160);
    check("b2b_first", 32'(bus.rx_data), 32'h00);
    send_frame(8'hFF, 1'b1, -1, 0, 160);
    check("ovr_pulse", 32'(n_ovr - o0),   32'd1);
    check("ovr_data",  32'(bus.rx_data),  32'h00);
    check("ovr_valid", 32'(bus.rx_valid), 32'd1);
    check("ovr_rises", 32'(n_rise - r0),  32'd1);
    ack_pulse();
    check("ovr_ack",   32'(bus.rx_valid), 32'd0);

    // Same again, but ack lands in the capture clk of the second byte.
    o0 = n_ovr;
    send_frame(8'h00, 1'b1, -1, 0, 160);
    send_frame(8'hFF, 1'b1, 156, 0, 160);
    check("ackcap_data",  32'(bus.rx_data),  32'hFF);
    check("ackcap_valid", 32'(bus.rx_valid), 32'd1);
    check("ackcap_novr",  32'(n_ovr - o0),   32'd0);
    ack_pulse();
    check("ackcap_ack",   32'(bus.rx_valid), 32'd0);

    // Start glitch of 4 clks.
    b0 = n_busy; r0 = n_rise; f0 = n_ferr; o0 = n_ovr;
    rx = 1'b0;
    tick_n(4);
    rx = 1'b1;
    tick_n(40);
    check("gl_busyseen", 32'(n_busy > b0),   32'd1);
    check("gl_busy",     32'(bus.busy),      32'd0);
    check("gl_novalid",  32'(n_rise - r0),   32'd0);
    check("gl_noflags",  32'((n_ferr - f0) + (n_ovr - o0)), 32'd0);

    // Stop bit low then line break of 200 clks.
    f0 = n_ferr;
    send_frame(8'h3C, 1'b0, -1, 0, 160);
    rx = 1'b0;
    tick_n(200);
    check("fe_pulse",  32'(n_ferr - f0),   32'd1);
    check("fe_brk",    32'(bus.busy),      32'd1);
    check("fe_valid",  32'(bus.rx_valid),  32'd0);
    rx = 1'b1;
    tick_n(5);
    check("fe_idle",   32'(bus.busy),      32'd0);
    tick_n(20);
    send_frame(8'h3C, 1'b1, -1, 0, 160);
    check("fe_next_valid", 32'(bus.rx_valid), 32'd1);
    check("fe_next_data",  32'(bus.rx_data),  32'h3C);
    check("fe_once",       32'(n_ferr - f0),  32'd1);
    ack_pulse();

    // Edge jitter of +/-1 clk.
    send_frame(8'h55, 1'b1, -1, 1, 160);
    check("jit_valid", 32'(bus.rx_valid), 32'd1);
    check("jit_data",  32'(bus.rx_data),  32'h55);

    // Reset halfway through another frame.
    f0 = n_ferr; o0 = n_ovr;
    send_frame(8'h96, 1'b1, -1, 0, 80);
    reset = 1'b1;
    rx    = 1'b1;
    tick_n(3);
    check("mid_rst_valid", 32'(bus.rx_valid), 32'd0);
    check("mid_rst_data",  32'(bus.rx_data),  32'h00);
    check("mid_rst_busy",  32'(bus.busy),     32'd0);
    reset = 1'b0;
    r0 = n_rise;
    tick_n(200);
    check("abort_novalid", 32'(n_rise - r0), 32'd0);
    check("abort_noflags", 32'((n_ferr - f0) + (n_ovr - o0)), 32'd0);
    check("abort_idle",    32'(bus.busy),    32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_rx_core.md
Name: uart_rx_core

Overview:
- Oversampling UART receiver for 8-bit data, 1 start bit, 1 stop bit, LSB first, idle-high line.
- Pairs with the team's UART transmitter on the same link.
- Runs entirely in the clk domain; no derived clocks.
- Delivers each byte through a hold-until-acknowledged valid/ack handshake, with framing and overrun flags.

Parameters:
- CLK_FREQ, 125000000, system clock frequency in Hz.
- BAUD_RATE, 115200, line bit rate in bits/s.
- OVERSAMPLE, 16, sample ticks per bit; must be an even number of at least 8.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- rx  in  1  asynchronous serial input, idle high.
- rx_ack  in  1  consumer acknowledge; clears rx_valid.
- rx_data  out  8  received byte; stable while rx_valid=1.
- rx_valid  out  1  level; high from byte capture until acknowledged.
- frame_err  out  1  one-clk pulse: stop bit sampled low.
- overrun  out  1  one-clk pulse: byte completed while the previous byte is unacknowledged; the new byte is dropped.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset, synchronous active-high:
  - state=IDLE; rx_data=0, rx_valid=0, frame_err=0, overrun=0, busy=0.
  - Synchronizer flops set to 1; all counters 0.
- Input conditioning: rx passes through a 2-flop synchronizer; rx_s is the second flop. All logic uses rx_s only.
- Tick generator:
  - DIV = CLK_FREQ/(BAUD_RATE*OVERSAMPLE), integer division, floor, minimum 1.
  - tick pulses for 1 clk every DIV clks.
  - Divider and sample counter are cleared on start-edge detection, so sampling phase is set by the start edge.
- Sampling: sample counter s runs 0..OVERSAMPLE-1 per bit. Bit value = majority vote of rx_s at ticks s=M-1, M, M+1, where M=OVERSAMPLE/2.
- IDLE: rx_s falling edge (previous 1, current 0) -> START.
- START: at vote point, majority 1 -> false start, back to IDLE, no flags. Majority 0 -> DATA, bit index=0.
- DATA:
  - At each vote point, shift the voted bit into shift_reg[7] and right-shift; LSB arrives first.
  - After bit index 7 -> STOP.
- STOP, at vote point:
  - Majority 1, consumer ready: rx_data<=shift_reg and rx_valid<=1 on the next clk edge -> IDLE. No mid-stop wait; the next start edge is accepted immediately.
  - Majority 1, rx_valid already 1 and rx_ack=0 that clk: overrun pulse, rx_data unchanged -> IDLE.
  - Majority 0: frame_err pulse, byte discarded -> BREAK.
- BREAK: wait for rx_s=1 on any clk -> IDLE. This suppresses repeated errors during a line break.
- Handshake:
  - rx_ack with rx_valid=1 clears rx_valid the next clk.
  - rx_ack with rx_valid=0 has no effect.
  - If rx_ack and a new capture occur in the same clk, the capture wins: rx_valid stays 1, rx_data is updated, no overrun.
- Latency: rx_valid rises exactly 1 clk after the stop-bit vote tick. Worst case from stop-bit midpoint on the pin is 2 synchronizer clks + 3 ticks + 1 clk.
- Reset asserted mid-frame aborts the frame: no flags, state IDLE.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- When defined:
  - One even-parity bit follows bit 7; the DATA state is followed by a PARITY state sampled like a data bit.
  - Output parity_err (1 bit) pulses for 1 clk in the stop-bit vote clk if the XOR of the 8 data bits and the parity bit is 1; the byte is discarded (rx_valid not set).
  - A frame error takes precedence over a parity error: only frame_err pulses.
- When undefined: 10-bit frame, no parity_err port, no PARITY state.

Test Plan (CLK_FREQ=16000000, BAUD_RATE=1000000, OVERSAMPLE=16, so DIV=1 and 16 clks per bit):
- Reset, rx held 1 for 100 clks -> all outputs 0, busy=0.
- Send 0xA5 with a clean frame -> rx_valid=1 with rx_data=0xA5; pulse rx_ack -> rx_valid=0 next clk.
- Back-to-back 0x00 then 0xFF, no ack -> first byte 0xA5-style capture of 0x00, then overrun pulse, rx_data stays 0x00. Repeat with rx_ack in the capture clk -> rx_data=0xFF, no overrun.
- Start glitch: rx low for 4 clks -> busy pulses, then IDLE; no rx_valid, no flags.
- Stop bit forced 0 while sending 0x3C, then rx held low for 200 clks -> exactly one frame_err pulse; returns to IDLE only after rx=1; next 0x3C received correctly.
- Stimulus jitter ±1 clk on each edge while sending 0x55, and reset asserted mid-byte on another frame -> 0x55 captured; the aborted frame yields no output.
